// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and defaults for the multiply/divide sequencer
package md_pkg;

    // md_op encodings as presented by EX
    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // sequencer states
    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    // default latencies, start edge to HI/LO update edge
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude for the most negative value
    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational multiply/divide datapath for the latched MD operation
module md_arith
    import md_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [31:0] hi_res_o,
    output logic [31:0] lo_res_o,
    output logic        div0_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] num_mag;
    logic [31:0] den_mag;
    logic [31:0] den_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Signed product: low 64 bits of the product of the sign-extended operands.
    assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    // Signed division runs on magnitudes and fixes signs afterwards: quotient
    // negative when operand signs differ, remainder follows the dividend.
    assign signed_div = (op_i == MD_DIV);
    assign div0_o     = (rt_i == 32'd0);
    assign num_mag    = signed_div ? md_abs(rs_i) : rs_i;
    assign den_mag    = signed_div ? md_abs(rt_i) : rt_i;
    // keep the divider X-free on a zero divisor; the result is discarded anyway
    assign den_safe   = div0_o ? 32'd1 : den_mag;
    assign quo_mag    = num_mag / den_safe;
    assign rem_mag    = num_mag % den_safe;
    assign quo        = (signed_div && (rs_i[31] ^ rt_i[31])) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem        = (signed_div && rs_i[31]) ? (~rem_mag + 32'd1) : rem_mag;

    // Select the result pair for the latched operation.
    always_comb begin
        hi_res_o = 32'd0;
        lo_res_o = 32'd0;
        case (op_i)
            MD_MULT: begin
                hi_res_o = prod_s[63:32];
                lo_res_o = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_res_o = prod_u[63:32];
                lo_res_o = prod_u[31:0];
            end
            default: begin
                hi_res_o = rem;
                lo_res_o = quo;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - HI/LO owner and fixed-latency MULT/DIV sequencer with pipeline stall
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  md_op_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    input  logic        hilo_we_i,
    input  logic        hilo_sel_i,
    input  logic [31:0] hilo_wdata_i,
    input  logic        id_md_use_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic [31:0]      rs_q,    rs_d;
    logic [31:0]      rt_q,    rt_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             div0;

    md_arith u_arith (
        .op_i     (op_q),
        .rs_i     (rs_q),
        .rt_i     (rt_q),
        .hi_res_o (hi_res),
        .lo_res_o (lo_res),
        .div0_o   (div0)
    );

    // Next-state: launch from IDLE (start beats MTHI/MTLO), count down in BUSY,
    // commit on the last count unless the divisor was zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    op_d    = md_op_i;
                    rs_d    = rs_val_i;
                    rt_d    = rt_val_i;
                    cnt_d   = md_op_i[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else if (hilo_we_i) begin
                    if (hilo_sel_i) begin
                        hi_d = hilo_wdata_i;
                    end else begin
                        lo_d = hilo_wdata_i;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    if (!(op_q[1] && div0)) begin
                        hi_d = hi_res;
                        lo_d = lo_res;
                    end
                end
            end
        endcase
    end

    // State registers; reset drops any in-flight result and clears HI/LO.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o  = (state_q == MD_BUSY);
    // covers the launch cycle too, so ID cannot slip an MD instruction past it
    assign stall_o = id_md_use_i & (busy_o | start_i);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the 5-stage MIPS pipeline. It owns the HI/LO register pair and runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations launched from EX. While an operation is running it asserts `busy`, and it raises `stall` toward the hazard/stall logic when the instruction in ID needs HI/LO or the MD unit. It also applies MTHI/MTLO writes and supplies HI/LO to EX for MFHI/MFLO.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO update for MULT/MULTU (≥1)
- DIV_CYCLES, 10, cycles from start to HI/LO update for DIV/DIVU (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  EX holds an MD arithmetic instruction this cycle
- md_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; valid with start
- rs_val  in  32  forwarded rs operand; valid with start
- rt_val  in  32  forwarded rt operand; valid with start
- hilo_we  in  1  EX holds MTHI/MTLO
- hilo_sel  in  1  0=LO, 1=HI; valid with hilo_we
- hilo_wdata  in  32  rs value for MTHI/MTLO
- id_md_use  in  1  ID instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- busy  out  1  operation in progress
- stall  out  1  freeze PC/IF_ID, bubble ID_EX
- hi  out  32  current HI
- lo  out  32  current LO

## Operation
- Two states: IDLE and BUSY. There is a down-counter `cnt`, wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
- IDLE to BUSY happens on a clock edge with start=1.
  - At that edge, rs_val, rt_val and md_op are latched.
  - cnt is loaded with MULT_CYCLES or DIV_CYCLES.
- In BUSY, cnt decrements each edge.
  - On the edge where cnt==1, HI/LO are written from the latched operation and the state returns to IDLE.
- Results:
  - MULT/MULTU: {HI,LO} = the 64-bit signed or unsigned product.
  - DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0: the operation still takes DIV_CYCLES and busy behaves normally, but HI/LO keep their prior values.
- hilo_we in IDLE writes hilo_wdata into the selected register at the edge.
- Priority and illegal inputs:
  - start and hilo_we together: start wins and hilo_we is ignored.
  - start or hilo_we while BUSY: ignored. The stall contract makes this illegal; the bench flags it with an assertion.
- stall = id_md_use & (busy | start). Any MD-class instruction in ID therefore waits through the whole operation, including the launch cycle.
- busy = (state==BUSY).
- hi/lo are driven directly from registers. There is no bypass of an in-flight result.

## Timing
- Reset values: state=IDLE, cnt=0, hi=0, lo=0, busy=0, stall=0 (stall also requires id_md_use=0).
- start sampled at edge E0:
  - busy=1 in the N cycles following E0.
  - HI/LO take the new value at edge EN (N = MULT_CYCLES or DIV_CYCLES).
  - busy=0 in the cycle after EN.
  - An MFHI held in ID reads the new HI in EX one cycle after EN.
- Back-to-back: a second start is accepted at EN+1 at the earliest.
- An MTHI/MTLO write is visible on hi/lo the cycle after its edge.
- Reset mid-operation: the next edge returns to IDLE, discards the pending result and clears HI/LO. No late write may occur.

## Structure
- Shared package `md_pkg`: the md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the state encoding (MD_IDLE, MD_BUSY), and default latencies.
- One sub-module, `md_arith`: combinational.
  - Inputs: latched operands and op.
  - Outputs: 64-bit {hi_res, lo_res} plus a div0 flag.
- The sequencer keeps only the FSM, counter, operand latches, HI/LO registers and stall logic.

## Test plan
- Reset, then MULT with rs=0xFFFFFFFF (-1), rt=2 → busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV with rs=-7, rt=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with rs=7, rt=0 → busy 10 cycles, HI/LO unchanged.
- Launch MULT with id_md_use=1 held → stall=1 from the start cycle through the last busy cycle (6 cycles), then 0. With id_md_use=0 → stall stays 0.
- MTLO 0x12345678, then MTHI 0xCAFEBABE on the next cycle → lo and hi update one cycle after each. start and hilo_we in the same cycle → only the MD result lands.
- Start DIV, assert reset at cycle 4 → busy=0, HI=LO=0 the next cycle, no write at the original cycle-10 edge.
- Back-to-back: MULT completes at EN, a second MULT is started at EN+1 → it is accepted and completes at EN+6.
